// File: rtl/usb_fs_xcvr.sv
// usb_fs_xcvr: full-speed USB pad front end.
// Receive path: synchronise -> deglitch filter -> J/K decode -> echo mask.
// Transmit path: one register stage to the pads. Connection detect runs
// on the filtered line state with host pulldowns assumed.
module usb_fs_xcvr #(
  parameter int SYNC_STAGES       = 2,
  parameter int FILTER_CYCLES     = 2,
  parameter int CONN_CYCLES       = 120,
  parameter int TURNAROUND_CYCLES = 4
) (
  input  logic clk_i,
  input  logic n_rst_i,
  input  logic usb_dp_i,
  input  logic usb_dn_i,
  output logic usb_dp_o,
  output logic usb_dn_o,
  output logic usb_tx_oen,
  input  logic phy_tx_dp_i,
  input  logic phy_tx_dn_i,
  input  logic phy_tx_oen_i,
  output logic phy_rx_rcv_o,
  output logic phy_rx_dp_o,
  output logic phy_rx_dn_o,
  output logic line_conn_o,
  output logic conn_change_o
);

  localparam int FCW = $clog2(FILTER_CYCLES + 1);
  localparam int CCW = $clog2(CONN_CYCLES + 1);
  localparam int TAW = (TURNAROUND_CYCLES > 0) ? $clog2(TURNAROUND_CYCLES + 1) : 1;

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_J   = 2'b10;

  typedef enum logic {DISC = 1'b0, CONN = 1'b1} conn_state_t;

  logic [SYNC_STAGES-1:0] r_dp_sync, r_dn_sync;
  logic [1:0]             w_s;
  logic [1:0]             r_cand, r_filt;
  logic [FCW-1:0]         r_fc, w_fc_nxt;
  logic                   w_filt_ld;
  logic [TAW-1:0]         r_ta;
  logic                   w_mask;
  logic                   r_rcv, w_rcv_nxt;
  logic                   r_rx_rcv, r_rx_dp, r_rx_dn;
  logic                   r_tx_dp, r_tx_dn, r_tx_oen;
  conn_state_t            r_state, w_state_nxt;
  logic [CCW-1:0]         r_cc, w_cc_nxt, w_cc_inc;
  logic                   w_qual;
  logic                   r_line_conn, r_conn_chg;

  // Pad inputs are asynchronous: plain shift-register synchronisers.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_dp_sync <= '0;
      r_dn_sync <= '0;
    end else begin
      r_dp_sync <= {r_dp_sync[SYNC_STAGES-2:0], usb_dp_i};
      r_dn_sync <= {r_dn_sync[SYNC_STAGES-2:0], usb_dn_i};
    end
  end

  assign w_s = {r_dp_sync[SYNC_STAGES-1], r_dn_sync[SYNC_STAGES-1]};

  // Run length of identical synced samples; restarts at 1 on any change.
  always_comb begin
    w_fc_nxt = r_fc;
    if (w_s != r_cand)                   w_fc_nxt = FCW'(1);
    else if (r_fc != FCW'(FILTER_CYCLES)) w_fc_nxt = r_fc + 1'b1;
  end

  // Accept the sample once the run length hits the threshold; while
  // saturated the reload is harmless since the candidate is unchanged.
  assign w_filt_ld = (w_fc_nxt == FCW'(FILTER_CYCLES));

  // Candidate tracks the last synced sample; filtered pair updates on accept.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_cand <= LS_SE0;
      r_fc   <= '0;
      r_filt <= LS_SE0;
    end else begin
      r_cand <= w_s;
      r_fc   <= w_fc_nxt;
      if (w_filt_ld) r_filt <= w_s;
    end
  end

  // Turnaround counter reloads every cycle the pads are driven.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i)           r_ta <= '0;
    else if (!phy_tx_oen_i) r_ta <= TAW'(TURNAROUND_CYCLES);
    else if (r_ta != '0)    r_ta <= r_ta - 1'b1;
  end

  // Mask is live in the same cycle the transmitter enables.
  assign w_mask = !phy_tx_oen_i || (r_ta != '0);

  // J/K decode; SE0 and SE1 keep the last differential value.
  always_comb begin
    w_rcv_nxt = r_rcv;
    case (r_filt)
      LS_J:    w_rcv_nxt = 1'b1;
      LS_K:    w_rcv_nxt = 1'b0;
      default: w_rcv_nxt = r_rcv;
    endcase
  end

  // Rx outputs: decoded state underneath, forced to idle J while masked.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_rcv    <= 1'b1;
      r_rx_rcv <= 1'b1;
      r_rx_dp  <= 1'b0;
      r_rx_dn  <= 1'b0;
    end else begin
      r_rcv    <= w_rcv_nxt;
      r_rx_rcv <= w_mask | w_rcv_nxt;
      r_rx_dp  <= w_mask | r_filt[1];
      r_rx_dn  <= !w_mask & r_filt[0];
    end
  end

  // Transmit registers; reset releases the pads immediately.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_tx_dp  <= 1'b0;
      r_tx_dn  <= 1'b0;
      r_tx_oen <= 1'b1;
    end else begin
      r_tx_dp  <= phy_tx_dp_i;
      r_tx_dn  <= phy_tx_dn_i;
      r_tx_oen <= phy_tx_oen_i;
    end
  end

  // A cycle qualifies only if it shows the state that would flip the status
  // and no transmit/turnaround is hiding the line.
  assign w_qual   = !w_mask && ((r_state == DISC) ? (r_filt == LS_J) : (r_filt == LS_SE0));
  assign w_cc_inc = (r_cc == CCW'(CONN_CYCLES)) ? r_cc : r_cc + 1'b1;

  // Connection next state: flip when the qualifying run reaches the limit.
  always_comb begin
    w_state_nxt = r_state;
    w_cc_nxt    = '0;
    if (w_qual) begin
      if (w_cc_inc == CCW'(CONN_CYCLES)) begin
        w_state_nxt = (r_state == DISC) ? CONN : DISC;
        w_cc_nxt    = '0;
      end else begin
        w_cc_nxt = w_cc_inc;
      end
    end
  end

  // Connection state register and run counter.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_state <= DISC;
      r_cc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cc    <= w_cc_nxt;
    end
  end

  // Registered status; the change pulse coincides with the status edge.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_line_conn <= 1'b0;
      r_conn_chg  <= 1'b0;
    end else begin
      r_line_conn <= (r_state == CONN);
      r_conn_chg  <= (r_state == CONN) != r_line_conn;
    end
  end

  assign usb_dp_o      = r_tx_dp;
  assign usb_dn_o      = r_tx_dn;
  assign usb_tx_oen    = r_tx_oen;
  assign phy_rx_rcv_o  = r_rx_rcv;
  assign phy_rx_dp_o   = r_rx_dp;
  assign phy_rx_dn_o   = r_rx_dn;
  assign line_conn_o   = r_line_conn;
  assign conn_change_o = r_conn_chg;

endmodule

// File: tb/tb_usb_fs_xcvr.sv
// tb_usb_fs_xcvr: directed + randomized bench for usb_fs_xcvr with a
// per-edge reference model built from pad/tx input history.
module tb_usb_fs_xcvr;
  localparam int SYNC = 2, FILT = 2, CONN = 120, TA = 4, MAXK = 4096;
  localparam logic [1:0] SE0 = 2'b00, K = 2'b01, J = 2'b10;
  localparam logic [2:0] IDLE = 3'b001, TXK = 3'b010, TXJ = 3'b100;
  localparam logic [7:0] RST_V = 8'b0011_0000;

  logic clk_i = 1'b0, n_rst_i = 1'b1;
  logic usb_dp_i = 1'b1, usb_dn_i = 1'b0;
  logic phy_tx_dp_i = 1'b0, phy_tx_dn_i = 1'b0, phy_tx_oen_i = 1'b1;
  logic usb_dp_o, usb_dn_o, usb_tx_oen;
  logic phy_rx_rcv_o, phy_rx_dp_o, phy_rx_dn_o, line_conn_o, conn_change_o;

  usb_fs_xcvr #(.SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT), .CONN_CYCLES(CONN),
                .TURNAROUND_CYCLES(TA)) dut (
    .clk_i(clk_i), .n_rst_i(n_rst_i), .usb_dp_i(usb_dp_i), .usb_dn_i(usb_dn_i),
    .usb_dp_o(usb_dp_o), .usb_dn_o(usb_dn_o), .usb_tx_oen(usb_tx_oen),
    .phy_tx_dp_i(phy_tx_dp_i), .phy_tx_dn_i(phy_tx_dn_i), .phy_tx_oen_i(phy_tx_oen_i),
    .phy_rx_rcv_o(phy_rx_rcv_o), .phy_rx_dp_o(phy_rx_dp_o), .phy_rx_dn_o(phy_rx_dn_o),
    .line_conn_o(line_conn_o), .conn_change_o(conn_change_o));

  always #10 clk_i = ~clk_i;

  int n_chk = 0, n_err = 0, k = 0, run = 0;
  // History per rising edge since reset release (index = edge number).
  logic [1:0] p_h [MAXK];
  logic [1:0] f_h [MAXK];
  logic [2:0] tx_h [MAXK];
  logic       rcv_h [MAXK];
  logic       st_h [MAXK];
  logic       tog_h [MAXK];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {usb_dp_o, usb_dn_o, usb_tx_oen, phy_rx_rcv_o, phy_rx_dp_o, phy_rx_dn_o,
            line_conn_o, conn_change_o};
  endfunction

  // Synced sample seen by the core at edge j: pads from SYNC edges earlier.
  function automatic logic [1:0] ss(input int j);
    return (j > SYNC) ? p_h[j-SYNC] : 2'b00;
  endfunction

  task automatic model_init();
    k = 0; run = 0;
    f_h[0] = SE0; rcv_h[0] = 1'b1; st_h[0] = 1'b0; tog_h[0] = 1'b0;
  endtask

  // One clock: drive inputs, advance model on the edge, check at negedge.
  task automatic cyc(input logic [1:0] pad, input logic [2:0] tx);
    bit eq, m, qual;
    logic st;
    logic [7:0] e;
    {usb_dp_i, usb_dn_i} = pad;
    {phy_tx_dp_i, phy_tx_dn_i, phy_tx_oen_i} = tx;
    @(posedge clk_i);
    k++;
    p_h[k] = pad; tx_h[k] = tx;
    // Line state accepted once the last FILT synced samples agree.
    eq = (k >= FILT);
    for (int j = 0; j < FILT; j++) if (k - j < 1 || ss(k-j) != ss(k)) eq = 0;
    f_h[k] = eq ? ss(k) : f_h[k-1];
    // Masked if tx was enabled on this edge or any of the TA before it.
    m = 0;
    for (int j = 0; j <= TA; j++) if (k - j >= 1 && !tx_h[k-j][0]) m = 1;
    rcv_h[k] = (f_h[k-1] == J) ? 1'b1 : (f_h[k-1] == K) ? 1'b0 : rcv_h[k-1];
    qual = !m && (st_h[k-1] ? (f_h[k-1] == SE0) : (f_h[k-1] == J));
    run = qual ? run + 1 : 0;
    st = st_h[k-1]; tog_h[k] = 1'b0;
    if (run == CONN) begin st = !st; tog_h[k] = 1'b1; run = 0; end
    st_h[k] = st;
    e = {tx_h[k], m ? 1'b1 : rcv_h[k], m ? 1'b1 : f_h[k-1][1], m ? 1'b0 : f_h[k-1][0],
         st_h[k-1], tog_h[k-1]};
    @(negedge clk_i);
    check("cyc", outs(), e);
  endtask

  task automatic reset_dut(input logic [1:0] pad, input logic [2:0] tx);
    {usb_dp_i, usb_dn_i} = pad;
    {phy_tx_dp_i, phy_tx_dn_i, phy_tx_oen_i} = tx;
    n_rst_i = 1'b0;
    #5;
    check("reset_vals", outs(), RST_V);
    @(negedge clk_i);
    n_rst_i = 1'b1;
    model_init();
  endtask

  initial begin
    int z;
    logic [1:0] pr;
    logic [2:0] tr;
    int len;
    #2;
    // Reset with pads at J, then pad-to-rx latency and connect timing.
    reset_dut(J, IDLE);
    repeat (4) cyc(J, IDLE);
    check("rx_lat4", {6'd0, phy_rx_dp_o, phy_rx_dn_o}, 8'd0);
    cyc(J, IDLE);
    check("rx_lat5", {6'd0, phy_rx_dp_o, phy_rx_dn_o}, {6'd0, J});
    repeat (119) cyc(J, IDLE);
    check("conn_124", {6'd0, line_conn_o, conn_change_o}, 8'd0);
    cyc(J, IDLE);
    check("conn_125", {6'd0, line_conn_o, conn_change_o}, 8'd3);
    cyc(J, IDLE);
    check("chg_126", {6'd0, line_conn_o, conn_change_o}, 8'd2);
    repeat (4) cyc(J, IDLE);
    // 1-cycle K glitch must not reach rx.
    z = 0;
    cyc(K, IDLE);
    repeat (10) begin cyc(J, IDLE); if (!phy_rx_rcv_o) z++; end
    check("glitch1", 8'(z), 8'd0);
    // 3-cycle K passes as 3 cycles of rcv=0.
    z = 0;
    repeat (3) begin cyc(K, IDLE); if (!phy_rx_rcv_o) z++; end
    repeat (10) begin cyc(J, IDLE); if (!phy_rx_rcv_o) z++; end
    check("glitch3", 8'(z), 8'd3);
    // Transmit K for 20 cycles with echo on the pads; rx must stay J.
    z = 0;
    cyc(K, TXK);
    check("tx_lat1", {5'd0, usb_dp_o, usb_dn_o, usb_tx_oen}, {5'd0, TXK});
    if ({phy_rx_rcv_o, phy_rx_dp_o, phy_rx_dn_o} != 3'b110) z++;
    repeat (19) begin cyc(K, TXK); if ({phy_rx_rcv_o, phy_rx_dp_o, phy_rx_dn_o} != 3'b110) z++; end
    repeat (4) begin cyc(J, IDLE); if ({phy_rx_rcv_o, phy_rx_dp_o, phy_rx_dn_o} != 3'b110) z++; end
    check("echo_mask", 8'(z), 8'd0);
    check("tx_release", {7'd0, usb_tx_oen}, 8'd1);
    repeat (10) cyc(J, IDLE);
    // Disconnect after 120 qualifying SE0 cycles; rcv holds through SE0.
    z = 0;
    repeat (124) begin cyc(SE0, IDLE); if (!phy_rx_rcv_o) z++; end
    check("se0_rcv_hold", 8'(z), 8'd0);
    check("disc_124", {6'd0, line_conn_o, conn_change_o}, 8'd2);
    cyc(SE0, IDLE);
    check("disc_125", {6'd0, line_conn_o, conn_change_o}, 8'd1);
    cyc(SE0, IDLE);
    check("disc_126", {6'd0, line_conn_o, conn_change_o}, 8'd0);

    // Mask arriving on the edge the count would hit its limit blocks connect.
    reset_dut(J, IDLE);
    repeat (123) cyc(J, IDLE);
    repeat (3) cyc(J, TXJ);
    check("mask_block", {7'd0, line_conn_o}, 8'd0);
    repeat (10) cyc(J, IDLE);
    check("mask_block2", {7'd0, line_conn_o}, 8'd0);
    repeat (120) cyc(J, IDLE);
    check("conn_after_mask", {7'd0, line_conn_o}, 8'd1);

    // J too short then SE0: no connect.
    reset_dut(J, IDLE);
    repeat (100) cyc(J, IDLE);
    repeat (60) cyc(SE0, IDLE);
    check("no_conn", {7'd0, line_conn_o}, 8'd0);

    // Randomized segments: short glitches, long runs, transmit bursts.
    reset_dut(SE0, IDLE);
    while (k < 1500) begin
      pr = 2'($urandom_range(0, 3));
      len = ($urandom_range(0, 3) == 0) ? 118 + $urandom_range(0, 14) : $urandom_range(1, 6);
      tr = ($urandom_range(0, 5) == 0) ? {2'($urandom_range(0, 3)), 1'b0} : IDLE;
      if (tr != IDLE && len > 12) len = 12;
      repeat (len) cyc(pr, tr);
    end

    // Async reset in the middle of a transmit: pads release at once.
    reset_dut(J, IDLE);
    repeat (130) cyc(J, IDLE);
    repeat (5) cyc(K, TXK);
    @(posedge clk_i);
    #3;
    n_rst_i = 1'b0;
    #1;
    check("async_rst", outs(), RST_V);
    @(posedge clk_i);
    #1;
    check("rst_hold_oen", {7'd0, usb_tx_oen}, 8'd1);
    {usb_dp_i, usb_dn_i} = J;
    {phy_tx_dp_i, phy_tx_dn_i, phy_tx_oen_i} = IDLE;
    @(negedge clk_i);
    n_rst_i = 1'b1;
    model_init();
    repeat (130) cyc(J, IDLE);
    check("reconn", {7'd0, line_conn_o}, 8'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/usb_fs_xcvr.md
# usb_fs_xcvr

Full-speed USB transceiver front end between the `usb_fs_phy` pad-side ports and the host's `usb_dp`/`usb_dn` pads. On receive it synchronises and deglitches the raw D+/D- inputs, then produces the PHY inputs `usb_rx_rcv`, `usb_rx_dp` and `usb_rx_dn`. On transmit it registers the PHY drive signals onto the pads, and suppresses receive echo during transmit and turnaround. It also detects device connect and disconnect from the filtered line state (host pulldowns active).

## Interface
- `SYNC_STAGES`, default 2: synchroniser flops per pad input (≥2).
- `FILTER_CYCLES`, default 2: consecutive identical synced samples needed to accept a new line state (≥1).
- `CONN_CYCLES`, default 120: cycles a state must persist to change connection status (2.5 µs at 48 MHz).
- `TURNAROUND_CYCLES`, default 4: cycles receive stays masked after transmit ends.

Ports:
- `clk_i` in 1: single clock, 48 MHz.
- `n_rst_i` in 1: reset, asynchronous, active-low.
- `usb_dp_i`, `usb_dn_i` in 1 each: raw pad inputs, asynchronous to `clk_i`.
- `usb_dp_o`, `usb_dn_o` out 1 each: pad drive.
- `usb_tx_oen` out 1: pad output enable, active-low (1 = tri-state/receive).
- `phy_tx_dp_i`, `phy_tx_dn_i`, `phy_tx_oen_i` in 1 each: from PHY `usb_tx_dp_o`, `usb_tx_dn_o`, `usb_tx_oen_o`.
- `phy_rx_rcv_o`, `phy_rx_dp_o`, `phy_rx_dn_o` out 1 each: to PHY `usb_rx_rcv_i`, `usb_rx_dp_i`, `usb_rx_dn_i`.
- `line_conn_o` out 1: device connected.
- `conn_change_o` out 1: one-cycle pulse when `line_conn_o` toggles.

## Operation
- **Synchroniser:** `SYNC_STAGES` flops each on dp and dn; reset to 0. The synced pair is `s = {dp, dn}`.
- **Filter:** holds candidate pair `c` and counter `fc`.
  - If `s != c`: `c <= s`, `fc <= 1`.
  - Else `fc` increments, saturating at `FILTER_CYCLES`.
  - The filtered pair `f` loads `c` in the cycle `fc` reaches `FILTER_CYCLES` while `s == c`.
  - Reset: `c = f = 00` (SE0), `fc = 0`.
- **Receive decode from `f`:**
  - J (10) sets `rcv = 1`; K (01) sets `rcv = 0`.
  - SE0 (00) and SE1 (11) hold the previous `rcv`. Reset `rcv = 1`.
  - `phy_rx_dp_o`/`phy_rx_dn_o` = `f`; `phy_rx_rcv_o` = `rcv`, all registered.
- **Echo mask:** `mask = 1` while `phy_tx_oen_i == 0`, and for `TURNAROUND_CYCLES` cycles after it returns to 1 (down-counter loaded on each low cycle).
  - While masked, the rx outputs are forced to J: dp = 1, dn = 0, rcv = 1.
  - The filter keeps running underneath.
  - When the mask ends, the outputs show the current `f`/`rcv` on the next cycle.
- **Transmit:** `usb_dp_o`, `usb_dn_o` and `usb_tx_oen` are registered copies of the `phy_tx_*` inputs.
  - Reset values: 0, 0, 1.
  - `usb_tx_oen` is never low during reset.
- **Connection FSM**, states `DISC` (reset) and `CONN`, with counter `cc` (width `$clog2(CONN_CYCLES+1)`, saturating):
  - In `DISC`, `cc` counts cycles with `f == J` and not masked. Any other cycle clears `cc`. When `cc` reaches `CONN_CYCLES`: go to `CONN`, clear `cc`, pulse.
  - In `CONN`, `cc` counts cycles with `f == SE0` and not masked. Anything else clears `cc`. When `cc` reaches `CONN_CYCLES`: go to `DISC`, clear `cc`, pulse.
  - Reset values: `line_conn_o = 0`, `conn_change_o = 0`.
- **Reset mid-operation:** every register returns to its reset value immediately (asynchronous). Pads release (`oen = 1`) with no glitch to drive.

## Timing
- **Pad to phy_rx:** a clean level change on pads reaches `phy_rx_*` after `SYNC_STAGES + FILTER_CYCLES + 1` clocks (5 with defaults).
- **Glitch rejection:** a pad pulse shorter than `FILTER_CYCLES` synced samples never changes `f`.
- **Transmit latency:** `phy_tx_*` to pads is 1 clock.
- **Mask:** applies in the same cycle `phy_tx_oen_i` falls; the first unmasked output cycle is `TURNAROUND_CYCLES + 1` after `phy_tx_oen_i` rises.
- **Connect/disconnect:** `line_conn_o` toggles `CONN_CYCLES` cycles after the qualifying `f` begins, and `conn_change_o` is high in that same cycle only.
- **Simultaneous events:** a mask starting in the cycle `cc` would hit its limit takes priority; no transition occurs and `cc` clears.
- **Filter at SE1:** SE1 is filtered like any pair but never counts toward connect or disconnect.

## Test plan
- **Reset:** assert `n_rst_i` with pads at J → outputs 0/0/1 tx, rx 00/rcv 1, `line_conn_o` 0; after release, `phy_rx_dp_o` = 1 on cycle 5.
- **Connect:** pads J for 130 cycles → `line_conn_o` rises at cycle 125 (5 latency + 120) with a one-cycle `conn_change_o`. J for 100 cycles then SE0 → no connect.
- **Glitch:** 1-cycle K pulse inside J → `phy_rx_*` unchanged. A 3-cycle K → `rcv` 0 for 3 cycles, delayed 5.
- **Transmit/echo:** `phy_tx_oen_i` low for 20 cycles driving K → pads K after 1 cycle; `phy_rx_*` reads J throughout plus 4 cycles after; a mask hitting at `cc` = 119 blocks connect.
- **Disconnect:** `CONN`, pads SE0 for 120 filtered cycles → `line_conn_o` falls with a pulse; during SE0, `rcv` holds its last value.
- **Async reset mid-transmit:** reset asserted mid-transmit → `usb_tx_oen` = 1 the same instant, FSM `DISC`.
